// File: rtl/pwm_multi_ch.sv
// N-channel PWM / RC-servo generator: shared prescaler and frame counter, double-buffered
// duty registers and mode, both committed only at a frame boundary so outputs never glitch.
module pwm_multi_ch #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIV_PWM     = 41,
  parameter int unsigned DIV_SERVO   = 781,
  parameter int unsigned SERVO_BASE  = 13,
  parameter int unsigned SERVO_SHIFT = 4,
  parameter int unsigned CH_W        = 2
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                ena,
  input  logic                mode_i,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                frame_o,
  output logic                mode_o
);

  localparam int unsigned DIV_MAX = (DIV_PWM > DIV_SERVO) ? DIV_PWM : DIV_SERVO;
  localparam int unsigned PRE_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned THR_W   = WIDTH + 1;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic                mode_q, mode_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                frame_q, frame_d;

  logic [PRE_W-1:0]    div_last;
  logic                tick;
  logic                fb;
  logic [THR_W-1:0]    thr [CHANNELS];

  // Timebase: prescaler divides clk into ticks, frame counter wraps naturally.
  always_comb begin
    div_last = mode_q ? PRE_W'(DIV_SERVO - 1) : PRE_W'(DIV_PWM - 1);
    tick     = ena && (pre_q == div_last);
    fb       = tick && (cnt_q == {WIDTH{1'b1}});

    pre_d = pre_q;
    if (tick) begin
      pre_d = '0;
    end else if (ena) begin
      pre_d = pre_q + PRE_W'(1);
    end
    cnt_d   = tick ? cnt_q + WIDTH'(1) : cnt_q;
    mode_d  = fb ? mode_i : mode_q;
    frame_d = fb;
  end

  // Duty buffers: active copies the pre-write shadow on fb, so a coincident write lands a frame later.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      active_d[i] = fb ? shadow_q[i] : active_q[i];
      shadow_d[i] = shadow_q[i];
      if (wr_en && (wr_ch == CH_W'(i))) begin
        shadow_d[i] = wr_duty;
      end
    end
  end

  // Per-channel compare in WIDTH+1 bits so the servo threshold cannot overflow.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      thr[i]   = mode_q ? (THR_W'(SERVO_BASE) + THR_W'(active_q[i] >> SERVO_SHIFT))
                        : {1'b0, active_q[i]};
      pwm_d[i] = ena && ({1'b0, cnt_q} < thr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      pwm_q   <= '0;
      frame_q <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_o   = pwm_q;
  assign frame_o = frame_q;
  assign mode_o  = mode_q;

endmodule
